bb_stim_responder: RTL and testbench
====================================

BB_STIM_RESPONDER -- requirements
Module: bb_stim_responder

Interface
REQ-001 Parameter WIDTH, default 4: lane count of request and response words.
REQ-002 Parameter INV_MASK, default 4'b0011: per-lane select; 1 = lane inverted, 0 = lane passed through.
REQ-003 Parameter LATENCY, default 2, legal range 1..7: cycles from request accept to first resp_valid.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a stimulus word.
REQ-007 req_ready  output  1  responder can accept a stimulus word.
REQ-008 req_data  input  WIDTH  stimulus word; lane i drives emulated blackbox i.
REQ-009 resp_valid  output  1  response word available.
REQ-010 resp_ready  input  1  initiator accepts the response word.
REQ-011 resp_data  output  WIDTH  response word.
REQ-012 resp_count  output  16  number of completed response handshakes.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement a 3-state FSM: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 exactly when the state is IDLE; no request is accepted in WAIT or RESP.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_data^INV_MASK SHALL be registered into the response register on that edge.
REQ-017 On accept with LATENCY=1 the next state SHALL be RESP; with LATENCY>1 the next state SHALL be WAIT, and a 3-bit down-counter SHALL load LATENCY-2.
REQ-018 In WAIT, the counter SHALL decrement once per cycle; when it is 0, the next state SHALL be RESP.
REQ-019 resp_valid SHALL be 1 exactly when the state is RESP, i.e. first asserted LATENCY cycles after the accept edge.
REQ-020 While resp_valid=1, resp_data SHALL hold stable until the handshake, regardless of req_valid or req_data.
REQ-021 A response handshake SHALL occur on a rising edge where resp_valid=1 and resp_ready=1; the next state SHALL be IDLE and resp_count SHALL increment by 1.
REQ-022 resp_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-023 resp_ready asserted outside RESP SHALL have no effect; req_valid asserted outside IDLE SHALL be ignored, and no data SHALL be captured.
REQ-024 Back-to-back operation: after a response handshake, the next accept SHALL be possible no earlier than the following edge, which is the first edge in IDLE.
REQ-025 resp_data SHALL be 0 when resp_valid=0.

Reset
REQ-026 While reset=1 at a rising edge, the state SHALL become IDLE, the counter and response register 0, and resp_count 0.
REQ-027 After reset: req_ready=1, resp_valid=0, resp_data=0, resp_count=0, busy=0.
REQ-028 Reset in WAIT or RESP SHALL discard the pending response without a handshake and without incrementing resp_count.
REQ-029 A req_valid asserted in the same cycle as reset=1 SHALL NOT be accepted.

Verification
REQ-030 Defaults; after reset, send req_data=4'b0101 with resp_ready=1 -> resp_valid rises exactly 2 cycles after the accept, resp_data=4'b0110, resp_count=1 after the handshake.
REQ-031 The four blackbox lanes, with req_data=4'b1010 (lane1 invNeg input 1, lane0 invPos input 0 inverted, lanes 3/2 pass) -> resp_data=4'b1001, and each lane is checked individually against its expected value.
REQ-032 Backpressure: hold resp_ready=0 for 5 cycles in RESP and toggle req_data -> resp_valid stays 1, resp_data is unchanged, req_ready stays 0, resp_count is unchanged until resp_ready=1.
REQ-033 LATENCY=1 and LATENCY=7 builds -> resp_valid is first high 1 and 7 cycles after the accept respectively; 10 back-to-back transactions complete and give resp_count=10.
REQ-034 Reset pulsed in WAIT and again in RESP -> next cycle state IDLE, resp_valid=0, resp_count retains 0, and a subsequent request completes normally.
REQ-035 Preload via 65535 handshakes, then one more -> resp_count reads 16'h0000.

Source files
------------

// File: rtl/bb_stim_responder.sv
`default_nettype none
// ============================================================================
//  Module   : bb_stim_responder
//  Function : Emulated blackbox stimulus/response block with a per-lane
//             invert mask and programmable request-to-response latency.
//  Revision : 1.0  initial release
// ============================================================================
module bb_stim_responder #(
    parameter int              WIDTH    = 4,
    parameter logic [WIDTH-1:0] INV_MASK = 4'b0011,
    parameter int              LATENCY  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [15:0]      resp_count,
    output logic             busy
);

    // WAIT spends LATENCY-2 extra cycles after the accept edge; LATENCY=1 skips it.
    localparam logic [2:0] c_LAT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
    localparam bit         c_DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [2:0]       r_latCnt;
    logic [2:0]       w_nextLatCnt;
    logic [WIDTH-1:0] r_respData;
    logic [WIDTH-1:0] w_nextRespData;
    logic [15:0]      r_respCount;
    logic [15:0]      w_nextRespCount;
    logic [WIDTH-1:0] w_laneOut;

    // Each lane models one blackbox: an inverting or a pass-through buffer.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            if (INV_MASK[gi]) begin : g_inv
                assign w_laneOut[gi] = ~req_data[gi];
            end else begin : g_pass
                assign w_laneOut[gi] = req_data[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_latCnt    <= 3'd0;
            r_respData  <= '0;
            r_respCount <= 16'd0;
        end else begin
            r_state     <= w_nextState;
            r_latCnt    <= w_nextLatCnt;
            r_respData  <= w_nextRespData;
            r_respCount <= w_nextRespCount;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_nextLatCnt    = r_latCnt;
        w_nextRespData  = r_respData;
        w_nextRespCount = r_respCount;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_nextRespData = w_laneOut;
                    if (c_DIRECT) begin
                        w_nextState = ST_RESP;
                    end else begin
                        w_nextState  = ST_WAIT;
                        w_nextLatCnt = c_LAT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (r_latCnt == 3'd0) begin
                    w_nextState = ST_RESP;
                end else begin
                    w_nextLatCnt = r_latCnt - 3'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_nextState     = ST_IDLE;
                    w_nextRespData  = '0;
                    w_nextRespCount = r_respCount + 16'd1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign busy       = (r_state != ST_IDLE);
    assign resp_data  = resp_valid ? r_respData : '0;
    assign resp_count = r_respCount;

endmodule
`default_nettype wire

// File: tb/tb_bb_stim_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bb_stim_responder
//  Function : Randomized self-checking bench for bb_stim_responder at
//             LATENCY 2 (default), 1 and 7.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bb_stim_responder;

    localparam logic [3:0] c_MASK = 4'b0011;

    logic        clock = 1'b0;
    logic        rst[3];
    logic        reqValid[3];
    logic        reqReady[3];
    logic [3:0]  reqData[3];
    logic        respValid[3];
    logic        respReady[3];
    logic [3:0]  respData[3];
    logic [15:0] respCount[3];
    logic        busySig[3];

    int nChecks = 0;
    int nErrors = 0;
    int modelCount[3];

    always #5 clock = ~clock;

    bb_stim_responder #(.WIDTH(4), .INV_MASK(4'b0011), .LATENCY(2)) u_dutL2 (
        .clock(clock), .reset(rst[0]),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_data(reqData[0]),
        .resp_valid(respValid[0]), .resp_ready(respReady[0]), .resp_data(respData[0]),
        .resp_count(respCount[0]), .busy(busySig[0])
    );

    bb_stim_responder #(.WIDTH(4), .INV_MASK(4'b0011), .LATENCY(1)) u_dutL1 (
        .clock(clock), .reset(rst[1]),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_data(reqData[1]),
        .resp_valid(respValid[1]), .resp_ready(respReady[1]), .resp_data(respData[1]),
        .resp_count(respCount[1]), .busy(busySig[1])
    );

    bb_stim_responder #(.WIDTH(4), .INV_MASK(4'b0011), .LATENCY(7)) u_dutL7 (
        .clock(clock), .reset(rst[2]),
        .req_valid(reqValid[2]), .req_ready(reqReady[2]), .req_data(reqData[2]),
        .resp_valid(respValid[2]), .resp_ready(respReady[2]), .resp_data(respData[2]),
        .resp_count(respCount[2]), .busy(busySig[2])
    );

    function automatic int latOf(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 7;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkIdle(input int k, input string tag);
        checkVal({tag, "_req_ready"},  32'(reqReady[k]),  32'd1);
        checkVal({tag, "_resp_valid"}, 32'(respValid[k]), 32'd0);
        checkVal({tag, "_resp_data"},  32'(respData[k]),  32'd0);
        checkVal({tag, "_busy"},       32'(busySig[k]),   32'd0);
        checkVal({tag, "_resp_count"}, 32'(respCount[k]), 32'(modelCount[k]));
    endtask

    // Called at a negedge with DUT k idle; returns at the negedge after the handshake.
    task automatic doTxn(input int k, input logic [3:0] d, input int stall);
        logic [3:0] exp;
        int lat;
        exp = d ^ c_MASK;
        checkVal("req_ready_before", 32'(reqReady[k]), 32'd1);
        reqValid[k] = 1'b1;
        reqData[k]  = d;
        @(negedge clock);
        reqValid[k] = 1'b0;
        lat = 1;
        while (!respValid[k] && lat < 20) begin
            checkVal("busy_wait", 32'(busySig[k]), 32'd1);
            respReady[k] = 1'($urandom_range(0, 1));
            reqValid[k]  = 1'($urandom_range(0, 1));
            reqData[k]   = 4'($urandom);
            @(negedge clock);
            lat++;
        end
        checkVal("latency", 32'(lat), 32'(latOf(k)));
        checkVal("resp_data", 32'(respData[k]), 32'(exp));
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("lane%0d", i), 32'(respData[k][i]), 32'(exp[i]));
        end
        checkVal("req_ready_resp", 32'(reqReady[k]), 32'd0);
        for (int s = 0; s < stall; s++) begin
            respReady[k] = 1'b0;
            reqValid[k]  = 1'($urandom_range(0, 1));
            reqData[k]   = 4'($urandom);
            @(negedge clock);
            checkVal("stall_resp_valid", 32'(respValid[k]), 32'd1);
            checkVal("stall_resp_data",  32'(respData[k]),  32'(exp));
            checkVal("stall_req_ready",  32'(reqReady[k]),  32'd0);
            checkVal("stall_resp_count", 32'(respCount[k]), 32'(modelCount[k]));
        end
        respReady[k] = 1'b1;
        @(negedge clock);
        respReady[k] = 1'b0;
        reqValid[k]  = 1'b0;
        modelCount[k] = (modelCount[k] + 1) & 16'hFFFF;
        checkIdle(k, "post_hs");
    endtask

    // Pulse reset while DUT k (default latency) holds a pending response.
    task automatic resetDuring(input int k, input bit inResp);
        reqValid[k] = 1'b1;
        reqData[k]  = 4'($urandom);
        @(negedge clock);
        reqValid[k] = 1'b0;
        if (inResp) begin
            @(negedge clock);
            checkVal("pre_rst_resp", 32'(respValid[k]), 32'd1);
        end else begin
            checkVal("pre_rst_wait_busy",  32'(busySig[k]),   32'd1);
            checkVal("pre_rst_wait_valid", 32'(respValid[k]), 32'd0);
        end
        rst[k]       = 1'b1;
        reqValid[k]  = 1'b1;
        respReady[k] = 1'b1;
        @(negedge clock);
        rst[k]       = 1'b0;
        reqValid[k]  = 1'b0;
        respReady[k] = 1'b0;
        modelCount[k] = 0;
        checkIdle(k, inResp ? "rst_in_resp" : "rst_in_wait");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]        = 1'b1;
            reqValid[k]   = 1'b0;
            reqData[k]    = 4'd0;
            respReady[k]  = 1'b0;
            modelCount[k] = 0;
        end
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        for (int k = 0; k < 3; k++) checkIdle(k, "reset");

        doTxn(0, 4'b0101, 0);
        checkVal("first_count", 32'(respCount[0]), 32'd1);
        doTxn(0, 4'b1010, 0);
        doTxn(0, 4'($urandom), 5);
        for (int n = 0; n < 10; n++) begin
            doTxn(0, 4'($urandom), int'($urandom_range(0, 3)));
        end

        resetDuring(0, 1'b0);
        resetDuring(0, 1'b1);
        doTxn(0, 4'($urandom), 1);
        checkVal("after_rst_count", 32'(respCount[0]), 32'd1);

        for (int k = 1; k < 3; k++) begin
            for (int n = 0; n < 10; n++) doTxn(k, 4'($urandom), 0);
            checkVal($sformatf("b2b_count_lat%0d", latOf(k)), 32'(respCount[k]), 32'd10);
        end

        // Stand in for 65533 earlier handshakes on the LATENCY=1 instance.
        force u_dutL1.r_respCount = 16'hFFFD;
        @(negedge clock);
        release u_dutL1.r_respCount;
        modelCount[1] = 16'hFFFD;
        doTxn(1, 4'($urandom), 0);
        doTxn(1, 4'($urandom), 0);
        checkVal("count_max", 32'(respCount[1]), 32'h0000FFFF);
        doTxn(1, 4'($urandom), 0);
        checkVal("count_wrap", 32'(respCount[1]), 32'h00000000);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
